// File: rtl/vlsu_pkg.sv
// Shared types and constants for the vector load/store unit.
package vlsu_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned VEC_W  = BYTE_W * LANES;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned VREG_W = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    localparam logic OP_VLD = 1'b0;
    localparam logic OP_VST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        LD_WB,
        ST_WR
    } state_e;

endpackage

// File: rtl/vlsu_addr_gen.sv
// Lane address generator: base + idx*stride, wrapping modulo 2^ADDR_W.
module vlsu_addr_gen
    import vlsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [IDX_W-1:0]  idx,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr
);

    assign addr = base + ADDR_W'(ADDR_W'(idx) * stride);

endmodule

// File: rtl/vector_load_store_unit.sv
// Multi-cycle mover between the vector register file and byte-wide data memory.
// Optional per-lane address stride enabled by defining VLSU_STRIDE_EN.
module vector_load_store_unit
    import vlsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [VREG_W-1:0] vreg,
    input  logic [ADDR_W-1:0] base,
`ifdef VLSU_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic [VREG_W-1:0] vrf_rreg,
    input  logic [VEC_W-1:0]  vrf_rdata,
    output logic [VREG_W-1:0] vrf_wreg,
    output logic [VEC_W-1:0]  vrf_wdata,
    output logic              vrf_write
);

    state_e                    state;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_n;
    logic [VREG_W-1:0]         vreg_q;
    logic [ADDR_W-1:0]         base_q;
    logic [ADDR_W-1:0]         stride_q;
    logic [ADDR_W-1:0]         stride_in;
    logic [VEC_W-1:0]          st_buf;
    logic [VEC_W-BYTE_W-1:0]   asm_q;
    logic [ADDR_W-1:0]         ag_base;
    logic [ADDR_W-1:0]         ag_stride;
    logic [IDX_W-1:0]          ag_idx;
    logic [ADDR_W-1:0]         ag_addr;

`ifdef VLSU_STRIDE_EN
    assign stride_in = stride;
`else
    assign stride_in = ADDR_W'(1);
`endif

    assign idx_n = idx + IDX_W'(1);

    // Register file is read combinationally while idle so VST can snapshot at acceptance.
    assign vrf_rreg = (state == IDLE && !reset) ? vreg : '0;

    // Outputs are registered, so the generator computes the address of the next lane.
    always_comb begin
        ag_base   = base_q;
        ag_idx    = idx_n;
        ag_stride = stride_q;
        if (state == IDLE) begin
            ag_base   = base;
            ag_idx    = '0;
            ag_stride = stride_in;
        end
    end

    vlsu_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .base   (ag_base),
        .idx    (ag_idx),
        .stride (ag_stride),
        .addr   (ag_addr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            vreg_q    <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            st_buf    <= '0;
            asm_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            vrf_wreg  <= '0;
            vrf_wdata <= '0;
            vrf_write <= 1'b0;
        end else begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            vrf_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vreg_q   <= vreg;
                        base_q   <= base;
                        stride_q <= stride_in;
                        idx      <= '0;
                        busy     <= 1'b1;
                        mem_addr <= ag_addr;
                        if (op == OP_VST) begin
                            st_buf    <= vrf_rdata;
                            mem_write <= 1'b1;
                            mem_wdata <= vrf_rdata[BYTE_W-1:0];
                            state     <= ST_WR;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= LD_REQ;
                        end
                    end
                end
                LD_REQ: begin
                    busy <= 1'b1;
                    // Read data trails the address by a cycle; shift bytes in from the top.
                    if (idx != '0) begin
                        asm_q <= {mem_rdata, asm_q[VEC_W-BYTE_W-1:BYTE_W]};
                    end
                    if (idx == LAST_IDX) begin
                        state <= LD_WAIT;
                    end else begin
                        idx      <= idx_n;
                        mem_read <= 1'b1;
                        mem_addr <= ag_addr;
                    end
                end
                LD_WAIT: begin
                    busy      <= 1'b1;
                    done      <= 1'b1;
                    vrf_write <= 1'b1;
                    vrf_wreg  <= vreg_q;
                    vrf_wdata <= {mem_rdata, asm_q};
                    state     <= LD_WB;
                end
                LD_WB: begin
                    state <= IDLE;
                end
                ST_WR: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx       <= idx_n;
                        busy      <= 1'b1;
                        done      <= (idx_n == LAST_IDX);
                        mem_write <= 1'b1;
                        mem_addr  <= ag_addr;
                        mem_wdata <= st_buf[{idx_n, 3'b000} +: BYTE_W];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Scoreboard bench for vector_load_store_unit with memory and register-file models.
module tb_vector_load_store_unit;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        done;
    } ev_t;

    localparam logic [1:0] K_RD = 2'd0;
    localparam logic [1:0] K_WR = 2'd1;
    localparam logic [1:0] K_VW = 2'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [1:0]  vreg;
    logic [7:0]  base;
`ifdef VLSU_STRIDE_EN
    logic [7:0]  stride;
`endif
    logic        busy, done, mem_read, mem_write, vrf_write;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  vrf_rreg, vrf_wreg;
    logic [31:0] vrf_rdata, vrf_wdata;

    logic [7:0]  mem [256];
    logic [31:0] regs [4];
    logic        tb_mem_we;
    logic [7:0]  tb_mem_a, tb_mem_d;
    logic        ext_we;
    logic [1:0]  ext_reg;
    logic [31:0] ext_data;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    always #5 clock = ~clock;

    vector_load_store_unit dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .vreg      (vreg),
        .base      (base),
`ifdef VLSU_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .vrf_rreg  (vrf_rreg),
        .vrf_rdata (vrf_rdata),
        .vrf_wreg  (vrf_wreg),
        .vrf_wdata (vrf_wdata),
        .vrf_write (vrf_write)
    );

    // Synchronous byte memory with a bench-side preload port.
    always @(posedge clock) begin
        if (mem_read) mem_rdata <= mem[mem_addr];
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (tb_mem_we) mem[tb_mem_a] <= tb_mem_d;
    end

    assign vrf_rdata = regs[vrf_rreg];

    always @(posedge clock) begin
        if (vrf_write) regs[vrf_wreg] <= vrf_wdata;
        else if (ext_we) regs[ext_reg] <= ext_data;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_rd(input logic [7:0] a);
        exp_q.push_back('{kind: K_RD, addr: a, data: 32'h0, done: 1'b0});
    endfunction

    function automatic void push_wr(input logic [7:0] a, input logic [7:0] d, input logic dn);
        exp_q.push_back('{kind: K_WR, addr: a, data: {24'h0, d}, done: dn});
    endfunction

    function automatic void push_vw(input logic [1:0] r, input logic [31:0] d);
        exp_q.push_back('{kind: K_VW, addr: {6'h0, r}, data: d, done: 1'b1});
    endfunction

    // Monitor: every memory or register-file transaction must match the queue head.
    always @(negedge clock) begin
        ev_t act;
        ev_t e;
        if (!reset) begin
            if (mem_read && mem_write) check("rw_exclusive", 64'd1, 64'd0);
            if (mem_read || mem_write || vrf_write) begin
                act.kind = mem_read ? K_RD : (mem_write ? K_WR : K_VW);
                act.addr = vrf_write && !mem_read && !mem_write ? {6'h0, vrf_wreg} : mem_addr;
                act.data = mem_write ? {24'h0, mem_wdata} : (vrf_write ? vrf_wdata : 32'h0);
                act.done = done;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'(act), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("event", 64'(act), 64'(e));
                end
            end else if (done) begin
                check("spurious_done", 64'd1, 64'd0);
            end
        end
    end

    task automatic poke_mem(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        tb_mem_we = 1'b1; tb_mem_a = a; tb_mem_d = d;
        @(posedge clock); #1;
        tb_mem_we = 1'b0;
    endtask

    task automatic poke_reg(input logic [1:0] r, input logic [31:0] d);
        @(negedge clock);
        ext_we = 1'b1; ext_reg = r; ext_data = d;
        @(posedge clock); #1;
        ext_we = 1'b0;
    endtask

    task automatic launch(input logic o, input logic [1:0] r, input logic [7:0] b);
        @(negedge clock);
        start = 1'b1; op = o; vreg = r; base = b;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!busy) break;
            cyc++;
        end
    endtask

    int n;
    int seen;

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; vreg = 2'd0; base = 8'h0;
        tb_mem_we = 1'b0; tb_mem_a = 8'h0; tb_mem_d = 8'h0;
        ext_we = 1'b0; ext_reg = 2'd0; ext_data = 32'h0;
`ifdef VLSU_STRIDE_EN
        stride = 8'd1;
`endif
        #3;
        check("rst_ctrl", 64'({busy, done, mem_read, mem_write, vrf_write}), 64'h0);
        check("rst_addr_data", 64'({mem_addr, mem_wdata, vrf_wreg, vrf_rreg}), 64'h0);
        check("rst_vrf_wdata", 64'(vrf_wdata), 64'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        poke_mem(8'h10, 8'h11); poke_mem(8'h11, 8'h22);
        poke_mem(8'h12, 8'h33); poke_mem(8'h13, 8'h44);
        poke_mem(8'hFE, 8'hA1); poke_mem(8'hFF, 8'hB2);
        poke_mem(8'h00, 8'hC3); poke_mem(8'h01, 8'hD4);
        poke_reg(2'd1, 32'hDEADBEEF);
        check("idle_no_done", 64'({busy, done}), 64'h0);

        // Basic VLD
        push_rd(8'h10); push_rd(8'h11); push_rd(8'h12); push_rd(8'h13);
        push_vw(2'd2, 32'h44332211);
        launch(1'b0, 2'd2, 8'h10);
        count_busy(n);
        check("vld_busy_cycles", 64'(n), 64'd6);
        check("vld_reg2", 64'(regs[2]), 64'h44332211);

        // Basic VST
        push_wr(8'h20, 8'hEF, 1'b0); push_wr(8'h21, 8'hBE, 1'b0);
        push_wr(8'h22, 8'hAD, 1'b0); push_wr(8'h23, 8'hDE, 1'b1);
        launch(1'b1, 2'd1, 8'h20);
        count_busy(n);
        check("vst_busy_cycles", 64'(n), 64'd4);
        check("vst_mem", 64'({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}), 64'hDEADBEEF);

        // Address wrap
        push_rd(8'hFE); push_rd(8'hFF); push_rd(8'h00); push_rd(8'h01);
        push_vw(2'd3, 32'hD4C3B2A1);
        launch(1'b0, 2'd3, 8'hFE);
        count_busy(n);
        check("wrap_reg3", 64'(regs[3]), 64'hD4C3B2A1);

        // start held through busy and done, then accepted in the next idle cycle
        push_rd(8'h10); push_rd(8'h11); push_rd(8'h12); push_rd(8'h13);
        push_vw(2'd0, 32'h44332211);
        push_wr(8'h40, 8'hEF, 1'b0); push_wr(8'h41, 8'hBE, 1'b0);
        push_wr(8'h42, 8'hAD, 1'b0); push_wr(8'h43, 8'hDE, 1'b1);
        @(negedge clock);
        start = 1'b1; op = 1'b0; vreg = 2'd0; base = 8'h10;
        @(posedge clock); #1;
        op = 1'b1; vreg = 2'd1; base = 8'h40;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done) begin seen = 1; break; end
        end
        check("held_start_done_seen", 64'(seen), 64'd1);
        @(negedge clock);
        check("held_start_idle_gap", 64'(busy), 64'd0);
        @(posedge clock); #1;
        start = 1'b0;
        count_busy(n);
        check("held_start_vst_busy", 64'(n), 64'd4);
        check("held_start_mem", 64'({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}), 64'hDEADBEEF);

        // Reset during LD_REQ idx=2
        push_rd(8'h10); push_rd(8'h11);
        launch(1'b0, 2'd3, 8'h10);
        @(posedge clock);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("abort_ctrl", 64'({busy, done, mem_read, mem_write, vrf_write}), 64'h0);
        check("abort_addr", 64'(mem_addr), 64'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_reg3_kept", 64'(regs[3]), 64'hD4C3B2A1);
        check("abort_queue_drained", 64'(exp_q.size()), 64'd0);
        push_rd(8'h20); push_rd(8'h21); push_rd(8'h22); push_rd(8'h23);
        push_vw(2'd3, 32'hDEADBEEF);
        launch(1'b0, 2'd3, 8'h20);
        count_busy(n);
        check("post_abort_busy", 64'(n), 64'd6);
        check("post_abort_reg3", 64'(regs[3]), 64'hDEADBEEF);

        // VST snapshot: source overwritten the cycle after acceptance
        push_wr(8'h50, 8'h11, 1'b0); push_wr(8'h51, 8'h22, 1'b0);
        push_wr(8'h52, 8'h33, 1'b0); push_wr(8'h53, 8'h44, 1'b1);
        launch(1'b1, 2'd0, 8'h50);
        ext_we = 1'b1; ext_reg = 2'd0; ext_data = 32'hCAFEF00D;
        @(posedge clock); #1;
        ext_we = 1'b0;
        count_busy(n);
        check("snapshot_mem", 64'({mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}), 64'h44332211);
        check("snapshot_reg0_updated", 64'(regs[0]), 64'hCAFEF00D);

`ifdef VLSU_STRIDE_EN
        poke_mem(8'h00, 8'h01); poke_mem(8'h04, 8'h02);
        poke_mem(8'h08, 8'h03); poke_mem(8'h0C, 8'h04);
        push_rd(8'h00); push_rd(8'h04); push_rd(8'h08); push_rd(8'h0C);
        push_vw(2'd1, 32'h04030201);
        stride = 8'd4;
        launch(1'b0, 2'd1, 8'h00);
        stride = 8'd1;
        count_busy(n);
        check("stride_reg1", 64'(regs[1]), 64'h04030201);
`endif

        repeat (3) @(negedge clock);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vector_load_store_unit.md
Name: vector_load_store_unit

Overview:
- Multi-cycle mover between the 4x32-bit vector register file and the 8-bit-wide data memory.
- Vector load (VLD): reads 4 consecutive bytes from memory, packs them, and writes the word into one vector register through the file's write port.
- Vector store (VST): reads one vector register through a file read port and writes its 4 byte lanes to memory.
- Sits beside the scalar datapath; the control FSM launches it and stalls until done.

Parameters:
- ADDR_W, 8, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- LANES, 4, byte lanes per vector word; fixed at 4, vector width = 8*LANES.

Ports:
- clock  input  1  clock; all state updates on posedge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  launch request; sampled only in IDLE.
- op  input  1  0 = VLD, 1 = VST.
- vreg  input  2  target (VLD) or source (VST) vector register.
- base  input  ADDR_W  start byte address.
- busy  output  1  high from the cycle after acceptance through the final active cycle.
- done  output  1  one-cycle pulse on the final active cycle.
- mem_addr  output  ADDR_W  memory address.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_wdata  output  8  store byte.
- mem_rdata  input  8  read data, valid the cycle after mem_read/mem_addr are presented (synchronous RAM).
- vrf_rreg  output  2  register-file read select.
- vrf_rdata  input  32  register-file read data (combinational).
- vrf_wreg  output  2  register-file write select.
- vrf_wdata  output  32  register-file write data.
- vrf_write  output  1  register-file write enable.

Behaviour:
- Reset: state IDLE, idx=0, assembly/store registers=0. All outputs 0: busy, done, mem_read, mem_write, vrf_write, mem_addr, mem_wdata, vrf_wdata, vrf_wreg, vrf_rreg.
- IDLE:
  - vrf_rreg = vreg, combinationally.
  - On posedge with start=1, latch op, vreg and base.
  - VST also latches vrf_rdata into the store buffer at this edge.
  - Then go to LD_REQ or ST_WR with idx=0.
- LD_REQ, idx 0..3:
  - mem_read=1, mem_addr=base+idx (wrapping).
  - Byte for idx k-1 is captured into bits [8(k-1)+7 : 8(k-1)] when idx=k≥1 (little-endian: byte at base goes to [7:0]).
  - After idx=3, go to LD_WAIT.
- LD_WAIT: mem_read=0; capture byte 3 into [31:24]; go to LD_WB.
- LD_WB:
  - vrf_write=1, vrf_wreg=latched vreg, vrf_wdata=assembled word; done=1.
  - Return to IDLE.
  - VLD latency: 6 busy cycles after the acceptance edge.
- ST_WR, idx 0..3:
  - mem_write=1, mem_addr=base+idx, mem_wdata=buffer byte idx.
  - done=1 during idx=3, then return to IDLE.
  - VST latency: 4 busy cycles.
- mem_read and mem_write are never high together; vrf_write is high only in LD_WB.
- start while busy is ignored, not queued. start in the same cycle done is high is also ignored; it is accepted from the following IDLE cycle.
- VST snapshots the register at acceptance; later register-file writes do not affect the bytes stored.
- Address wrap: base=0xFE accesses FE, FF, 00, 01.
- Reset mid-operation: immediate abort to IDLE. No further memory or register-file writes; a partially assembled VLD is discarded.
- done is not asserted after reset.

Optional Feature:
- Macro: VLSU_STRIDE_EN.
- Defined: extra input stride [ADDR_W-1:0], latched at acceptance; lane address = base + idx*stride, wrapping. stride=0 re-accesses one byte 4 times.
- Undefined: no stride port; stride fixed at 1.

Decomposition:
- Shared package vlsu_pkg holds:
  - state encoding (IDLE, LD_REQ, LD_WAIT, LD_WB, ST_WR);
  - op constants (OP_VLD=0, OP_VST=1);
  - LANES constant.
- One natural sub-module, vlsu_addr_gen: combinational base + idx*stride with wrap, stride tied to 1 when the feature is off.

Test Plan:
- VLD, mem[0x10..0x13]=11,22,33,44, vreg=2 -> reads at 10,11,12,13 on consecutive cycles; vrf_write one cycle with wdata=0x44332211, wreg=2; done coincident; busy 6 cycles.
- VST, v1=0xDEADBEEF, base=0x20 -> mem writes 20:EF, 21:BE, 22:AD, 23:DE over 4 cycles; done on the 4th; vrf_write never high.
- Wrap: VLD base=0xFE -> addresses FE, FF, 00, 01; word assembled in that order.
- start pulsed during busy and during done -> ignored; a second start in the next IDLE cycle is accepted normally.
- reset asserted during LD_REQ idx=2 -> outputs 0 immediately; no vrf_write; target register unchanged; a subsequent VLD completes correctly.
- VST source modified by an external write the cycle after acceptance -> memory receives the pre-write value. With VLSU_STRIDE_EN and stride=4, base=0 -> addresses 0, 4, 8, C.
